// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and counter sizing for the serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// full_subtractor_cell: one-bit full subtractor, d = x - y - bi with borrow-out bo
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // borrow when x < y, or when x == y and a borrow arrives
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin with valid/ready on both sides
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, amsb_q, bmsb_q, bout_q, ovf_q;
    logic             d_d, br_d;

    full_subtractor_cell u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (br_q),
        .d  (d_d),
        .bo (br_d)
    );

    // control FSM and serial datapath; results latch only when entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    br_q    <= bin;
                    cnt_q   <= '0;
                    amsb_q  <= a[WIDTH-1];
                    bmsb_q  <= b[WIDTH-1];
                    state_q <= RUN;
                end
                RUN: begin
                    br_q  <= br_d;
                    r_q   <= {d_d, r_q[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        diff_q  <= {d_d, r_q[WIDTH-1:1]};
                        bout_q  <= br_d;
                        ovf_q   <= (amsb_q != bmsb_q) && (d_d != amsb_q);
                        state_q <= DONE;
                    end
                end
                DONE: if (done_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign done_valid  = (state_q == DONE);
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign ovf         = ovf_q;

endmodule
